// File: rtl/alu_serial_negate_if.sv
// Handshake and data bundle for the bit-serial complement unit.
// The requester drives start/mode/a; the unit returns status and result.
interface alu_serial_negate_if #(
  parameter int WIDTH = 16
);
  logic             start;
  logic             mode;
  logic [WIDTH-1:0] a;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             carry;
  logic             zero;
  logic             ovf;

  modport master (
    output start, mode, a,
    input  busy, done, result, carry, zero, ovf
  );

  modport slave (
    input  start, mode, a,
    output busy, done, result, carry, zero, ovf
  );
endinterface

// File: rtl/alu_serial_negate.sv
// Bit-serial complement unit: ones' complement (mode=0) or two's complement
// negate (mode=1), one bit per clock, LSB first.
// The operand register doubles as the accumulator: every shift pushes the
// complemented bit in at the MSB, so after WIDTH shifts it holds the answer.
// Visible outputs are separate registers that only update on leaving DONE,
// so partial shift contents never reach the result port.
module alu_serial_negate #(
  parameter int WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  alu_serial_negate_if.slave    bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [WIDTH-1:0] MSB_ONLY = {1'b1, {(WIDTH-1){1'b0}}};
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_next;

  logic [WIDTH-1:0] sreg;
  logic [CNT_W-1:0] cnt;
  logic             cy;
  logic             mode_q;
  logic             ovf_q;

  logic [WIDTH-1:0] result_q;
  logic             carry_q;
  logic             zero_q;
  logic             ovf_out_q;
  logic             done_q;

  logic             capture;
  logic             shift_en;
  logic             finish;
  logic             last_bit;
  logic             out_bit;

  assign last_bit = (cnt == LAST_CNT);
  assign out_bit  = ~sreg[0] ^ cy;

  // State register; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state decode and the per-state datapath strobes.
  always_comb begin
    state_next = state;
    capture    = 1'b0;
    shift_en   = 1'b0;
    finish     = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          capture    = 1'b1;
          state_next = SHIFT;
        end
      end
      SHIFT: begin
        shift_en = 1'b1;
        if (last_bit) begin
          state_next = DONE;
        end
      end
      DONE: begin
        finish     = 1'b1;
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operand capture and the serial complement/+1 chain; the counter holds at
  // its last value on the final shift so it never wraps.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg   <= '0;
      cnt    <= '0;
      cy     <= 1'b0;
      mode_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (capture) begin
      sreg   <= bus.a;
      cy     <= bus.mode;
      cnt    <= '0;
      mode_q <= bus.mode;
      ovf_q  <= bus.mode && (bus.a == MSB_ONLY);
    end else if (shift_en) begin
      sreg <= {out_bit, sreg[WIDTH-1:1]};
      cy   <= ~sreg[0] & cy;
      if (!last_bit) begin
        cnt <= cnt + 1'b1;
      end
    end
  end

  // Publish result and flags on leaving DONE, with a one-cycle done pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_q  <= '0;
      carry_q   <= 1'b0;
      zero_q    <= 1'b0;
      ovf_out_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= finish;
      if (finish) begin
        result_q  <= sreg;
        carry_q   <= cy & mode_q;
        zero_q    <= (sreg == '0);
        ovf_out_q <= ovf_q;
      end
    end
  end

  assign bus.busy   = (state != IDLE);
  assign bus.done   = done_q;
  assign bus.result = result_q;
  assign bus.carry  = carry_q;
  assign bus.zero   = zero_q;
  assign bus.ovf    = ovf_out_q;

endmodule
